// File: rtl/fft_out_uart_scheduler.sv
// fft_out_uart_scheduler
// Reads the FFT result RAM (rd_ptr 0..N-1) after the last butterfly stage. Each complex sample
// {Re, Im} is captured, sign-extended to whole bytes and sent MSB-first to the UART TX byte port.
// Handshake: a byte moves on a rising clk edge when tx_valid && tx_ready. Once tx_valid is high,
// tx_data and tx_valid hold until that transfer. tx_valid is registered, so there is no
// combinational path from tx_ready.
// Optional feature: define FFT_OUT_HEADER_EN to send a 0xA5 sync byte and an 8-bit frame count
// before each frame.
// The current FSM state is kept in the internal signal 'state' so checkers can bind to it.
module fft_out_uart_scheduler #(
    parameter int bit_width = 24,
    parameter int N         = 16,
    parameter int SIZE      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_flag,
    output logic [SIZE-1:0]      rd_ptr,
    output logic                 en_rd,
    input  logic [bit_width-1:0] Re_i,
    input  logic [bit_width-1:0] Im_i,
    input  logic                 ram_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done_o
);

    localparam int BYTES = (bit_width + 7) / 8;
    localparam int W     = BYTES * 8;
    localparam int NB    = 2 * BYTES;
    localparam int CW    = $clog2(NB);

`ifdef FFT_OUT_HEADER_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_READ = 3'd2,
        S_WAIT = 3'd3,
        S_SEND = 3'd4,
        S_DONE = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd2,
        S_WAIT = 3'd3,
        S_SEND = 3'd4,
        S_DONE = 3'd5
    } state_t;
`endif

    state_t            state;
    logic [CW-1:0]     byte_cnt;
    logic [2*W-1:0]    cap;
    logic signed [W-1:0] re_ext;
    logic signed [W-1:0] im_ext;
`ifdef FFT_OUT_HEADER_EN
    logic [7:0]        frame_cnt;
`endif

    // Sign-extend the RAM words to a whole number of bytes before slicing
    assign re_ext = W'($signed(Re_i));
    assign im_ext = W'($signed(Im_i));

    // Readout sequencer. All outputs are registered. The capture register shifts left one byte
    // per transfer, so the next byte to send always sits just below the top byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rd_ptr   <= '0;
            en_rd    <= 1'b0;
            tx_data  <= 8'd0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done_o   <= 1'b0;
            byte_cnt <= '0;
            cap      <= '0;
`ifdef FFT_OUT_HEADER_EN
            frame_cnt <= 8'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_flag) begin
                        rd_ptr <= '0;
                        busy   <= 1'b1;
`ifdef FFT_OUT_HEADER_EN
                        state    <= S_HDR;
                        tx_data  <= 8'hA5;
                        tx_valid <= 1'b1;
                        byte_cnt <= '0;
`else
                        state <= S_READ;
                        en_rd <= 1'b1;
`endif
                    end
                end
`ifdef FFT_OUT_HEADER_EN
                S_HDR: begin
                    if (tx_valid && tx_ready) begin
                        if (byte_cnt == '0) begin
                            tx_data  <= frame_cnt;
                            byte_cnt <= CW'(1);
                        end else begin
                            tx_valid <= 1'b0;
                            byte_cnt <= '0;
                            en_rd    <= 1'b1;
                            state    <= S_READ;
                        end
                    end
                end
`endif
                S_READ: begin
                    en_rd <= 1'b0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ram_valid) begin
                        cap      <= {re_ext, im_ext};
                        tx_data  <= re_ext[W-1 -: 8];
                        tx_valid <= 1'b1;
                        byte_cnt <= '0;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_valid && tx_ready) begin
                        if (byte_cnt == CW'(NB - 1)) begin
                            tx_valid <= 1'b0;
                            byte_cnt <= '0;
                            if (rd_ptr == SIZE'(N - 1)) begin
                                done_o <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                rd_ptr <= rd_ptr + SIZE'(1);
                                en_rd  <= 1'b1;
                                state  <= S_READ;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + CW'(1);
                            tx_data  <= cap[2*W-9 -: 8];
                            cap      <= cap << 8;
                        end
                    end
                end
                S_DONE: begin
                    done_o <= 1'b0;
                    busy   <= 1'b0;
                    rd_ptr <= '0;
`ifdef FFT_OUT_HEADER_EN
                    frame_cnt <= frame_cnt + 8'd1;
`endif
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_out_uart_scheduler.sv
// Testbench for fft_out_uart_scheduler: RAM model, random UART backpressure, byte scoreboard.
// Define FFT_OUT_HEADER_EN for both the bench and the RTL to exercise the header build.
module tb_fft_out_uart_scheduler;

  localparam int BW    = 24;
  localparam int NP    = 16;
  localparam int SZ    = 4;
  localparam int BYTES = (BW + 7) / 8;

  logic          clk;
  logic          rst_n;
  logic          start_flag;
  logic [SZ-1:0] rd_ptr;
  logic          en_rd;
  logic [BW-1:0] re_i;
  logic [BW-1:0] im_i;
  logic          ram_valid;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          done_o;

  fft_out_uart_scheduler #(.bit_width(BW), .N(NP), .SIZE(SZ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_flag(start_flag),
    .rd_ptr    (rd_ptr),
    .en_rd     (en_rd),
    .Re_i      (re_i),
    .Im_i      (im_i),
    .ram_valid (ram_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done_o    (done_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    exp_q[$];
  int            n_vec;
  int            n_err;
  logic [BW-1:0] mem_re[NP];
  logic [BW-1:0] mem_im[NP];
  int            exp_addr;
  int            ready_low_pct;
  int            frame_model;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference model: a signed word becomes BYTES bytes, most significant first
  task automatic push_word(input logic [BW-1:0] w);
    int v;
    v = int'($signed(w));
    for (int j = BYTES - 1; j >= 0; j--) exp_q.push_back(8'((v >>> (8 * j)) & 255));
  endtask

  task automatic push_frame();
`ifdef FFT_OUT_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(frame_model));
`endif
    for (int k = 0; k < NP; k++) begin
      push_word(mem_re[k]);
      push_word(mem_im[k]);
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < NP; k++) begin
      mem_re[k] = BW'($urandom);
      mem_im[k] = BW'($urandom);
    end
  endtask

  // RAM model: one-cycle read latency plus a random extra delay
  initial begin
    int d;
    ram_valid = 1'b0;
    re_i = '0;
    im_i = '0;
    forever begin
      @(negedge clk);
      if (rst_n && en_rd) begin
        logic [SZ-1:0] a;
        a = rd_ptr;
        check("rd_ptr_order", 32'(a), 32'(exp_addr));
        exp_addr++;
        d = $urandom_range(0, 2);
        repeat (1 + d) @(posedge clk);
        #1;
        check("en_rd_one_cycle", 32'(en_rd), 32'd0);
        ram_valid = 1'b1;
        re_i = mem_re[a];
        im_i = mem_im[a];
        @(posedge clk);
        #1;
        ram_valid = 1'b0;
        re_i = BW'($urandom);
        im_i = BW'($urandom);
      end
    end
  end

  // UART readiness driver
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = ($urandom_range(0, 99) >= ready_low_pct);
    end
  end

  // monitor: pops the expected byte on every transfer and checks stability under stall
  initial begin
    logic       stalled;
    logic [7:0] held;
    logic [7:0] e;
    stalled = 1'b0;
    held = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid_hold", 32'(tx_valid), 32'd1);
          check("stall_data_hold", 32'(tx_data), 32'(held));
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_byte: got %02h expected none", tx_data);
          end else begin
            e = exp_q.pop_front();
            check("byte", 32'(tx_data), 32'(e));
          end
          stalled = 1'b0;
        end else if (tx_valid) begin
          stalled = 1'b1;
          held = tx_data;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  // driver: one frame, optionally with a stray start_flag mid-frame
  task automatic run_frame(input bit inject);
    bit got;
    exp_addr = 0;
    push_frame();
    @(posedge clk);
    #1;
    start_flag = 1'b1;
    @(posedge clk);
    #1;
    start_flag = 1'b0;
    @(negedge clk);
    check("start_busy", 32'(busy), 32'd1);
`ifdef FFT_OUT_HEADER_EN
    check("start_hdr_valid", 32'(tx_valid), 32'd1);
    check("start_hdr_data", 32'(tx_data), 32'hA5);
`else
    check("start_en_rd", 32'(en_rd), 32'd1);
    check("start_rd_ptr", 32'(rd_ptr), 32'd0);
`endif
    got = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      start_flag = (inject && c == 30);
      @(negedge clk);
      if (done_o) begin
        got = 1'b1;
        break;
      end
    end
    start_flag = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    if (got) begin
      check("done_busy", 32'(busy), 32'd1);
      check("done_all_bytes", 32'(exp_q.size()), 32'd0);
      check("done_all_reads", 32'(exp_addr), 32'(NP));
      frame_model = (frame_model + 1) % 256;
      @(negedge clk);
      check("after_done_busy", 32'(busy), 32'd0);
      check("after_done_pulse", 32'(done_o), 32'd0);
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        check("idle_quiet", 32'({en_rd, tx_valid, done_o, busy}), 32'd0);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    bit seen;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start_flag = 1'b0;
    ready_low_pct = 0;
    frame_model = 0;
    exp_addr = 0;

    // reset held: start toggling must have no effect
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start_flag = ~start_flag;
      check("rst_outputs", 32'({rd_ptr, en_rd, tx_data, tx_valid, busy, done_o}), 32'd0);
    end
    start_flag = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ramp pattern, no backpressure
    for (int k = 0; k < NP; k++) begin
      mem_re[k] = BW'(k * 4096);
      mem_im[k] = BW'(-k);
    end
    ready_low_pct = 0;
    run_frame(1'b0);

    // same pattern with backpressure
    ready_low_pct = 30;
    run_frame(1'b0);

    // random data with extreme negative / positive values
    fill_random();
    mem_re[0] = 24'h7FFFFF;
    mem_re[3] = 24'hFFFFFF;
    mem_im[3] = 24'h800000;
    mem_im[NP-1] = 24'h800000;
    run_frame(1'b0);

    // stray start during a frame is ignored; next start works
    fill_random();
    ready_low_pct = 0;
    run_frame(1'b1);
    fill_random();
    ready_low_pct = 20;
    run_frame(1'b0);

    // reset in the middle of a frame
    fill_random();
    exp_addr = 0;
    push_frame();
    @(posedge clk);
    #1;
    start_flag = 1'b1;
    @(posedge clk);
    #1;
    start_flag = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (tx_valid && exp_addr >= 3) begin
        seen = 1'b1;
        break;
      end
    end
    check("midframe_reached", 32'(seen), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 32'({rd_ptr, en_rd, tx_data, tx_valid, busy, done_o}), 32'd0);
    exp_q.delete();
    frame_model = 0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // recovery frame after the aborted one
    fill_random();
    ready_low_pct = 30;
    run_frame(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
